// File: rtl/reg_pipeline_if.sv
// Handshake bundle for reg_pipeline: upstream valid/ready/data, downstream valid/ready/data, occupancy.
// The master side drives items in and takes them out; the slave side is the pipeline itself.
interface reg_pipeline_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) ();
  logic                         in_valid;
  logic [WIDTH-1:0]             in_data;
  logic                         in_ready;
  logic                         out_valid;
  logic [WIDTH-1:0]             out_data;
  logic                         out_ready;
  logic [$clog2(DEPTH+1)-1:0]   occupancy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/reg_pipeline.sv
// DEPTH-stage valid/ready register pipeline with bubble collapse; DEPTH cycles from accept to output.
// Stalls propagate backwards only through full stages, combinationally from out_ready.
module reg_pipeline #(
  parameter int             WIDTH      = 8,
  parameter int             DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  reg_pipeline_if.slave     bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [DEPTH-1:0] rdy;

  // A stage is ready if it or any stage downstream of it is empty, or the sink accepts.
  always_comb begin : ready_chain
    logic r;
    r = !vld_q[DEPTH-1] || bus.out_ready;
    rdy = '0;
    rdy[DEPTH-1] = r;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      r = !vld_q[i] || r;
      rdy[i] = r;
    end
  end

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (flush) begin
      vld_d = '0;
    end else begin
      if (rdy[0]) begin
        vld_d[0] = bus.in_valid;
        if (bus.in_valid) dat_d[0] = bus.in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          vld_d[i] = vld_q[i-1];
          if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
        end
      end
    end
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OCC_W'(vld_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= RESET_DATA;
      end
    end else begin
      vld_q <= vld_d;
      occ_q <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign bus.in_ready  = rdy[0] && !flush && !rst;
  assign bus.out_valid = vld_q[DEPTH-1] && !flush && !rst;
  assign bus.out_data  = dat_q[DEPTH-1];
  assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_reg_pipeline.sv
// Bench for reg_pipeline: directed scenarios plus random traffic, checked every cycle against an
// item-position model of the pipe (items drift toward the output, packing behind a stalled head).
module tb_reg_pipeline;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam logic [WIDTH-1:0] RST_DAT = 8'h5A;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  reg_pipeline_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  reg_pipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_DATA(RST_DAT)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] d;
    int               pos;
  } item_t;

  item_t            mq[$];
  logic [WIDTH-1:0] pop_dat[$];
  int               pop_cyc[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor / reference model: compare what the DUT shows, then advance the model one edge.
  always @(negedge clk) begin
    logic  exp_ir, exp_ov;
    int    lim, np;
    item_t it;
    exp_ir = !rst && !flush && (mq.size() < DEPTH || bus.out_ready);
    exp_ov = !rst && !flush && mq.size() > 0 && mq[0].pos == DEPTH - 1;
    chk("mon_in_ready", 32'(bus.in_ready), 32'(exp_ir));
    chk("mon_out_valid", 32'(bus.out_valid), 32'(exp_ov));
    chk("mon_occupancy", 32'(bus.occupancy), 32'(mq.size()));
    if (exp_ov) chk("mon_out_data", 32'(bus.out_data), 32'(mq[0].d));
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (exp_ov && bus.out_ready) begin
        pop_dat.push_back(mq[0].d);
        pop_cyc.push_back(cyc);
        void'(mq.pop_front());
      end
      lim = DEPTH - 1;
      foreach (mq[k]) begin
        np = mq[k].pos + 1;
        if (np > lim) np = lim;
        mq[k].pos = np;
        lim = np - 1;
      end
      if (bus.in_valid && exp_ir) begin
        it.d = bus.in_data;
        it.pos = 0;
        mq.push_back(it);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, idx, rel;
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("reset_occupancy", 32'(bus.occupancy), 0);
    chk("reset_out_data", 32'(bus.out_data), 32'(RST_DAT));
    chk("reset_in_ready", 32'(bus.in_ready), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 1);
    chk("idle_out_valid", 32'(bus.out_valid), 0);
    step();

    // Latency: single item, out_valid appears in the 4th cycle after acceptance.
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'hA5;
    @(negedge clk);
    chk("lat_accept", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("lat_occupancy", 32'(bus.occupancy), (k <= 4) ? 1 : 0);
      chk("lat_out_valid", 32'(bus.out_valid), (k == 4) ? 1 : 0);
      if (k == 4) chk("lat_out_data", 32'(bus.out_data), 32'h A5);
      step();
    end

    // Streaming 0..15 at full rate.
    base = pop_dat.size();
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'(i);
      @(negedge clk);
      chk("stream_in_ready", 32'(bus.in_ready), 1);
      step();
    end
    idle(8);
    chk("stream_count", 32'(pop_dat.size() - base), 16);
    for (int i = 0; i < 16 && base + i < pop_dat.size(); i++) begin
      chk("stream_data", 32'(pop_dat[base+i]), 32'(i));
      chk("stream_cycle", 32'(pop_cyc[base+i] - pop_cyc[base]), 32'(i));
    end

    // Backpressure: 6 offered, 4 fit while the sink stalls.
    base = pop_dat.size();
    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'h30 + 8'(idx);
      @(negedge clk);
      if (bus.in_ready) idx++;
      step();
    end
    bus.in_data = 8'h30 + 8'(idx);
    @(negedge clk);
    chk("bp_accepted", 32'(idx), 4);
    chk("bp_in_ready_full", 32'(bus.in_ready), 0);
    chk("bp_occupancy", 32'(bus.occupancy), 4);
    step();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.in_valid = (idx < 6);
      bus.in_data = 8'h30 + 8'(idx);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) idx++;
      step();
    end
    bus.in_valid = 1'b0;
    chk("bp_total_accepted", 32'(idx), 6);
    chk("bp_pop_count", 32'(pop_dat.size() - base), 6);
    for (int i = 0; i < 6 && base + i < pop_dat.size(); i++) begin
      chk("bp_order", 32'(pop_dat[base+i]), 32'h30 + 32'(i));
    end

    // Bubble collapse: item, two idle cycles, item, sink stalled.
    base = pop_dat.size();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'hB1;
    step();
    idle(2);
    bus.in_valid = 1'b1;
    bus.in_data = 8'hB2;
    step();
    idle(4);
    @(negedge clk);
    chk("bubble_occupancy", 32'(bus.occupancy), 2);
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    rel = cyc;
    step();
    idle(3);
    chk("bubble_pop_count", 32'(pop_dat.size() - base), 2);
    if (pop_dat.size() - base >= 2) begin
      chk("bubble_first", 32'(pop_dat[base]), 32'hB1);
      chk("bubble_second", 32'(pop_dat[base+1]), 32'hB2);
      chk("bubble_first_cycle", 32'(pop_cyc[base]), 32'(rel));
      chk("bubble_adjacent", 32'(pop_cyc[base+1]), 32'(rel + 1));
    end

    // Flush with three items held and a new item offered.
    base = pop_dat.size();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'hC0 + 8'(i);
      step();
    end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'hEE;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_pre_occupancy", 32'(bus.occupancy), 3);
    chk("flush_in_ready", 32'(bus.in_ready), 0);
    chk("flush_out_valid", 32'(bus.out_valid), 0);
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_occupancy", 32'(bus.occupancy), 0);
    chk("flush_out_valid_after", 32'(bus.out_valid), 0);
    idle(6);
    chk("flush_no_output", 32'(pop_dat.size() - base), 0);

    // Reset mid-stream over a full pipe, together with flush.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'hFF;
      step();
    end
    @(negedge clk);
    chk("rst_full_occupancy", 32'(bus.occupancy), 4);
    step();
    rst = 1'b1;
    flush = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    step();
    rst = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("rst_occupancy", 32'(bus.occupancy), 0);
    chk("rst_out_data", 32'(bus.out_data), 32'(RST_DAT));
    chk("rst_out_valid_after", 32'(bus.out_valid), 0);
    step();

    // Random traffic with occasional flush and reset; sink bias changes per phase.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 39) == 0);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data = 8'($urandom);
      bus.out_ready = ((c / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                            : ($urandom_range(0, 3) == 0);
      step();
    end
    rst = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    idle(8);
    @(negedge clk);
    chk("final_empty", 32'(bus.occupancy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_pipeline.md
REG_PIPELINE -- requirements
Module: reg_pipeline

Interface
REQ-001 Parameter WIDTH, default 8, data bits per stage; the block SHALL support WIDTH >= 1.
REQ-002 Parameter DEPTH, default 4, number of register stages; the block SHALL support DEPTH >= 1.
REQ-003 Parameter RESET_DATA, default 0 (WIDTH bits), data value loaded into every stage by reset.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 flush  input  1  synchronous pipeline clear, active-high.
REQ-007 in_valid  input  1  upstream item present.
REQ-008 in_data  input  WIDTH  upstream item.
REQ-009 in_ready  output  1  block accepts the item this cycle.
REQ-010 out_valid  output  1  item present at the last stage.
REQ-011 out_data  output  WIDTH  data at the last stage.
REQ-012 out_ready  input  1  downstream accepts the item this cycle.
REQ-013 occupancy  output  $clog2(DEPTH+1)  registered count of valid stages.

Function
REQ-014 The block SHALL hold DEPTH stages, each with a WIDTH data register and a valid bit; stage 0 is fed by the input, and stage DEPTH-1 drives out_data/out_valid.
REQ-015 A transfer SHALL occur at input when in_valid && in_ready, and at output when out_valid && out_ready.
REQ-016 Stage i SHALL be ready when its valid bit is 0 or stage i+1 is ready; the last stage SHALL be ready when it is empty or out_ready=1. in_ready SHALL equal stage-0 ready && !flush.
REQ-017 A ready stage SHALL load data and valid from its predecessor, or from in_data/in_valid for stage 0; an empty predecessor SHALL propagate valid=0 into that stage.
REQ-018 A non-ready (stalled) stage SHALL hold its data and valid unchanged.
REQ-019 Bubbles SHALL collapse: a stalled downstream stage SHALL NOT block upstream stages behind an empty stage.
REQ-020 Latency: an item accepted at edge N into an empty pipeline with out_ready=1 SHALL show out_valid=1 with that data after edge N+DEPTH-1, which is DEPTH cycles from acceptance.
REQ-021 Throughput SHALL be one item per cycle while out_ready=1 and in_valid=1.
REQ-022 Ordering SHALL be strict FIFO; no item SHALL be duplicated or dropped, except by flush or reset.
REQ-023 out_valid SHALL equal last-stage valid && !flush; out_data SHALL equal last-stage data at all times.
REQ-024 On a cycle with flush=1 (rst=0), every valid bit SHALL clear at the edge, no input transfer SHALL occur, no output transfer SHALL occur, and data registers SHALL hold their values.
REQ-025 occupancy SHALL equal the number of set valid bits after each edge, with a range of 0..DEPTH.
REQ-026 When all stages are valid and out_ready=0, in_ready SHALL be 0; with out_ready=1 the same cycle, in_ready SHALL be 1 (simultaneous push/pop at full).
REQ-027 in_ready, out_valid, and out_data SHALL have no combinational path from in_data; the ready chain MAY be combinational from out_ready.

Reset
REQ-028 When rst=1 at a rising edge, all valid bits SHALL be 0, all data registers SHALL be RESET_DATA, and occupancy SHALL be 0 after that edge.
REQ-029 rst SHALL take priority over flush and over any transfer in the same cycle, including reset asserted mid-stream.
REQ-030 While rst=1, in_ready and out_valid SHALL be 0.

Verification
REQ-031 The bench SHALL cover latency: DEPTH=4, WIDTH=8, out_ready=1, one item 0xA5 -> out_valid=1 with out_data=0xA5 exactly 4 cycles after acceptance, and occupancy goes 1,1,1,1,0.
REQ-032 The bench SHALL cover streaming: 16 consecutive items 0..15 with out_ready=1 -> in_ready stays 1, and the outputs are 0..15 on consecutive cycles in order.
REQ-033 The bench SHALL cover backpressure: out_ready=0 while pushing 6 items -> 4 accepted, in_ready=0 after the pipe fills, occupancy=4; releasing out_ready -> all 6 emerge in order.
REQ-034 The bench SHALL cover bubble collapse: push item, idle 2 cycles, push item, with out_ready=0 -> both items end adjacent in stages 3 and 2, and occupancy=2.
REQ-035 The bench SHALL cover flush: flush asserted with occupancy=3 and in_valid=1 -> in_ready=0 and out_valid=0 that cycle, the input item is not accepted, and occupancy=0 next cycle.
REQ-036 The bench SHALL cover reset mid-stream: rst=1 with flush=1 and a pipe full of 0xFF -> occupancy=0, out_data=RESET_DATA, and out_valid=0 next cycle.
